// File: rtl/vga_state_snapshot.sv
// Double-buffers elevator display state and commits it at the start of vertical blanking.
// Define SNAPSHOT_OVERWRITE_EN to keep upd_ready high and let a newer update replace a held one.
module vga_state_snapshot #(
  parameter int unsigned VERT_PIXEL   = 480,
  parameter int unsigned FRAME_W      = 8,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic               pixel_clk,
  input  logic               reset,
  input  logic [9:0]         horiz_count,
  input  logic [9:0]         vert_count,
  input  logic               upd_valid,
  output logic               upd_ready,
  input  logic [7:0]         upd_destination,
  input  logic [1:0]         upd_sim_state,
  input  logic [25:0]        upd_people_data,
  output logic [7:0]         destination,
  output logic [1:0]         sim_state,
  output logic [25:0]        people_data,
  output logic [FRAME_W-1:0] frame_count,
  output logic               blink,
  output logic               pending
);

  localparam logic [9:0] COMMIT_LINE = 10'(VERT_PIXEL);
  localparam logic [7:0] BLINK_LAST  = 8'(BLINK_FRAMES - 1);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } state_e;

  state_e             state_q;
  logic               cond_q;
  logic [7:0]         sh_dest_q;
  logic [1:0]         sh_sim_q;
  logic [25:0]        sh_ppl_q;
  logic [7:0]         dest_q;
  logic [1:0]         sim_q;
  logic [25:0]        ppl_q;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [7:0]         blink_cnt_q, blink_cnt_d;
  logic               blink_q, blink_d;

  logic cond_s;
  logic tick_s;
  logic ready_s;
  logic accept_s;

  // Rising edge of the commit-point condition so a stalled counter yields one tick.
  always_comb begin
    cond_s = (horiz_count == 10'd0) && (vert_count == COMMIT_LINE);
    tick_s = cond_s && !cond_q;
`ifdef SNAPSHOT_OVERWRITE_EN
    ready_s = 1'b1;
`else
    ready_s = (state_q == ST_EMPTY) || tick_s;
`endif
    accept_s = upd_valid && ready_s;
  end

  // Frame counter and blink divider advance only on a tick.
  always_comb begin
    frame_d     = frame_q;
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    if (tick_s) begin
      frame_d = frame_q + FRAME_W'(1);
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = 8'd0;
        blink_d     = !blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 8'd1;
        blink_d     = blink_q;
      end
    end else begin
      frame_d     = frame_q;
      blink_cnt_d = blink_cnt_q;
      blink_d     = blink_q;
    end
  end

  // Shadow/commit state machine; outputs take the old shadow before any new capture.
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_EMPTY;
      cond_q    <= 1'b0;
      sh_dest_q <= 8'd0;
      sh_sim_q  <= 2'd0;
      sh_ppl_q  <= 26'd0;
      dest_q    <= 8'd0;
      sim_q     <= 2'd0;
      ppl_q     <= 26'd0;
    end else begin
      cond_q <= cond_s;
      case (state_q)
        ST_EMPTY: begin
          if (accept_s) begin
            sh_dest_q <= upd_destination;
            sh_sim_q  <= upd_sim_state;
            sh_ppl_q  <= upd_people_data;
            state_q   <= ST_HELD;
          end else begin
            state_q <= ST_EMPTY;
          end
        end
        ST_HELD: begin
          if (tick_s) begin
            dest_q <= sh_dest_q;
            sim_q  <= sh_sim_q;
            ppl_q  <= sh_ppl_q;
          end else begin
            dest_q <= dest_q;
          end
          if (accept_s) begin
            sh_dest_q <= upd_destination;
            sh_sim_q  <= upd_sim_state;
            sh_ppl_q  <= upd_people_data;
            state_q   <= ST_HELD;
          end else if (tick_s) begin
            state_q <= ST_EMPTY;
          end else begin
            state_q <= ST_HELD;
          end
        end
        default: begin
          state_q <= ST_EMPTY;
        end
      endcase
    end
  end

  // Frame and blink registers.
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      frame_q     <= '0;
      blink_cnt_q <= 8'd0;
      blink_q     <= 1'b0;
    end else begin
      frame_q     <= frame_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

  assign upd_ready   = ready_s;
  assign pending     = (state_q == ST_HELD);
  assign destination = dest_q;
  assign sim_state   = sim_q;
  assign people_data = ppl_q;
  assign frame_count = frame_q;
  assign blink       = blink_q;

endmodule

// File: tb/tb_vga_state_snapshot.sv
// Directed, table-driven bench for vga_state_snapshot (small FRAME_W/BLINK_FRAMES for wrap and blink).
module tb_vga_state_snapshot;

`ifdef SNAPSHOT_OVERWRITE_EN
  localparam bit OVR = 1'b1;
`else
  localparam bit OVR = 1'b0;
`endif
  localparam logic [25:0] P = 26'h3FFFFFF;
  localparam logic [25:0] Q = 26'h0000123;
  localparam logic [25:0] R = 26'h1555555;

  logic        pixel_clk = 1'b0;
  logic        reset;
  logic [9:0]  horiz_count, vert_count;
  logic        upd_valid, upd_ready;
  logic [7:0]  upd_destination, destination;
  logic [1:0]  upd_sim_state, sim_state;
  logic [25:0] upd_people_data, people_data;
  logic [1:0]  frame_count;
  logic        blink, pending;

  int checks = 0;
  int failures = 0;

  vga_state_snapshot #(.VERT_PIXEL(480), .FRAME_W(2), .BLINK_FRAMES(2)) dut (
    .pixel_clk(pixel_clk), .reset(reset),
    .horiz_count(horiz_count), .vert_count(vert_count),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_destination(upd_destination), .upd_sim_state(upd_sim_state),
    .upd_people_data(upd_people_data),
    .destination(destination), .sim_state(sim_state), .people_data(people_data),
    .frame_count(frame_count), .blink(blink), .pending(pending)
  );

  always #5 pixel_clk = ~pixel_clk;

  typedef struct {
    logic [9:0]  h, v;
    logic        vld;
    logic [7:0]  dst;
    logic [1:0]  sim;
    logic [25:0] ppl;
    logic        e_rdy, e_pend;
    logic [7:0]  e_dst;
    logic [1:0]  e_sim;
    logic [25:0] e_ppl;
    logic [1:0]  e_fc;
    logic        e_blk;
  } vec_t;

  vec_t tbl [23];

  function automatic vec_t mk(input logic [9:0] h, input logic [9:0] v, input logic vld,
                              input logic [7:0] dst, input logic [1:0] sim, input logic [25:0] ppl,
                              input logic rdy, input logic pnd, input logic [7:0] edst,
                              input logic [1:0] esim, input logic [25:0] eppl,
                              input logic [1:0] fc, input logic blk);
    vec_t r;
    r.h = h; r.v = v; r.vld = vld; r.dst = dst; r.sim = sim; r.ppl = ppl;
    r.e_rdy = rdy | OVR; r.e_pend = pnd; r.e_dst = edst; r.e_sim = esim;
    r.e_ppl = eppl; r.e_fc = fc; r.e_blk = blk;
    return r;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic [9:0] h, input logic [9:0] v, input logic vld,
                       input logic [7:0] dst, input logic [1:0] sim, input logic [25:0] ppl);
    horiz_count = h; vert_count = v; upd_valid = vld;
    upd_destination = dst; upd_sim_state = sim; upd_people_data = ppl;
  endtask

  task automatic step();
    @(posedge pixel_clk);
    #1;
  endtask

  initial begin
    // rows: inputs for this cycle, then expectations sampled before this cycle's edge
    tbl[0]  = mk(10'd5, 10'd100, 1'b0, 8'h00, 2'd0, 26'd0, 1'b1, 1'b0, 8'h00, 2'd0, 26'd0, 2'd0, 1'b0);
    tbl[1]  = mk(10'd0, 10'd480, 1'b0, 8'h00, 2'd0, 26'd0, 1'b1, 1'b0, 8'h00, 2'd0, 26'd0, 2'd0, 1'b0);
    tbl[2]  = mk(10'd5, 10'd100, 1'b0, 8'h00, 2'd0, 26'd0, 1'b1, 1'b0, 8'h00, 2'd0, 26'd0, 2'd1, 1'b0);
    tbl[3]  = mk(10'd0, 10'd480, 1'b0, 8'h00, 2'd0, 26'd0, 1'b1, 1'b0, 8'h00, 2'd0, 26'd0, 2'd1, 1'b0);
    tbl[4]  = mk(10'd5, 10'd100, 1'b0, 8'h00, 2'd0, 26'd0, 1'b1, 1'b0, 8'h00, 2'd0, 26'd0, 2'd2, 1'b1);
    tbl[5]  = mk(10'd0, 10'd480, 1'b0, 8'h00, 2'd0, 26'd0, 1'b1, 1'b0, 8'h00, 2'd0, 26'd0, 2'd2, 1'b1);
    tbl[6]  = mk(10'd5, 10'd100, 1'b0, 8'h00, 2'd0, 26'd0, 1'b1, 1'b0, 8'h00, 2'd0, 26'd0, 2'd3, 1'b1);
    tbl[7]  = mk(10'd5, 10'd100, 1'b1, 8'h24, 2'd2, P,     1'b1, 1'b0, 8'h00, 2'd0, 26'd0, 2'd3, 1'b1);
    tbl[8]  = mk(10'd5, 10'd100, 1'b0, 8'h00, 2'd0, 26'd0, 1'b0, 1'b1, 8'h00, 2'd0, 26'd0, 2'd3, 1'b1);
    tbl[9]  = mk(10'd5, 10'd100, !OVR, 8'h81, 2'd1, Q,     1'b0, 1'b1, 8'h00, 2'd0, 26'd0, 2'd3, 1'b1);
    tbl[10] = mk(10'd0, 10'd480, 1'b1, 8'h81, 2'd1, Q,     1'b1, 1'b1, 8'h00, 2'd0, 26'd0, 2'd3, 1'b1);
    tbl[11] = mk(10'd5, 10'd100, 1'b0, 8'h00, 2'd0, 26'd0, 1'b0, 1'b1, 8'h24, 2'd2, P,     2'd0, 1'b0);
    tbl[12] = mk(10'd0, 10'd480, 1'b0, 8'h00, 2'd0, 26'd0, 1'b1, 1'b1, 8'h24, 2'd2, P,     2'd0, 1'b0);
    tbl[13] = mk(10'd0, 10'd480, 1'b0, 8'h00, 2'd0, 26'd0, 1'b1, 1'b0, 8'h81, 2'd1, Q,     2'd1, 1'b0);
    tbl[14] = mk(10'd0, 10'd480, 1'b0, 8'h00, 2'd0, 26'd0, 1'b1, 1'b0, 8'h81, 2'd1, Q,     2'd1, 1'b0);
    tbl[15] = mk(10'd0, 10'd480, 1'b0, 8'h00, 2'd0, 26'd0, 1'b1, 1'b0, 8'h81, 2'd1, Q,     2'd1, 1'b0);
    tbl[16] = mk(10'd5, 10'd100, 1'b0, 8'h00, 2'd0, 26'd0, 1'b1, 1'b0, 8'h81, 2'd1, Q,     2'd1, 1'b0);
    tbl[17] = mk(10'd0, 10'd480, 1'b0, 8'h00, 2'd0, 26'd0, 1'b1, 1'b0, 8'h81, 2'd1, Q,     2'd1, 1'b0);
    tbl[18] = mk(10'd5, 10'd100, 1'b0, 8'h00, 2'd0, 26'd0, 1'b1, 1'b0, 8'h81, 2'd1, Q,     2'd2, 1'b1);
    tbl[19] = mk(10'd0, 10'd480, 1'b1, 8'h5A, 2'd3, R,     1'b1, 1'b0, 8'h81, 2'd1, Q,     2'd2, 1'b1);
    tbl[20] = mk(10'd5, 10'd100, 1'b0, 8'h00, 2'd0, 26'd0, 1'b0, 1'b1, 8'h81, 2'd1, Q,     2'd3, 1'b1);
    tbl[21] = mk(10'd0, 10'd480, 1'b0, 8'h00, 2'd0, 26'd0, 1'b1, 1'b1, 8'h81, 2'd1, Q,     2'd3, 1'b1);
    tbl[22] = mk(10'd5, 10'd100, 1'b0, 8'h00, 2'd0, 26'd0, 1'b1, 1'b0, 8'h5A, 2'd3, R,     2'd0, 1'b0);

    reset = 1'b1;
    drive(10'd5, 10'd100, 1'b0, 8'h00, 2'd0, 26'd0);
    step();
    step();
    chk("rst_pending", -1, 32'(pending), 32'd0);
    chk("rst_ready", -1, 32'(upd_ready), 32'd1);
    chk("rst_dest", -1, 32'(destination), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].h, tbl[i].v, tbl[i].vld, tbl[i].dst, tbl[i].sim, tbl[i].ppl);
      @(negedge pixel_clk);
      chk("ready", i, 32'(upd_ready), 32'(tbl[i].e_rdy));
      chk("pending", i, 32'(pending), 32'(tbl[i].e_pend));
      chk("destination", i, 32'(destination), 32'(tbl[i].e_dst));
      chk("sim_state", i, 32'(sim_state), 32'(tbl[i].e_sim));
      chk("people_data", i, 32'(people_data), 32'(tbl[i].e_ppl));
      chk("frame_count", i, 32'(frame_count), 32'(tbl[i].e_fc));
      chk("blink", i, 32'(blink), 32'(tbl[i].e_blk));
      step();
    end

    // Reset while HELD: the held update must be discarded.
    drive(10'd0, 10'd480, 1'b0, 8'h00, 2'd0, 26'd0);
    step();
    drive(10'd5, 10'd200, 1'b1, 8'h77, 2'd1, 26'h0ABCDEF);
    step();
    drive(10'd5, 10'd200, 1'b0, 8'h00, 2'd0, 26'd0);
    @(negedge pixel_clk);
    chk("pre_rst_pending", 100, 32'(pending), 32'd1);
    chk("pre_rst_fc", 100, 32'(frame_count), 32'd1);
    reset = 1'b1;
    #1;
    chk("async_rst_pending", 101, 32'(pending), 32'd0);
    chk("async_rst_ready", 101, 32'(upd_ready), 32'd1);
    chk("async_rst_dest", 101, 32'(destination), 32'd0);
    chk("async_rst_sim", 101, 32'(sim_state), 32'd0);
    chk("async_rst_ppl", 101, 32'(people_data), 32'd0);
    chk("async_rst_fc", 101, 32'(frame_count), 32'd0);
    step();
    reset = 1'b0;
    drive(10'd0, 10'd480, 1'b0, 8'h00, 2'd0, 26'd0);
    step();
    drive(10'd5, 10'd100, 1'b0, 8'h00, 2'd0, 26'd0);
    @(negedge pixel_clk);
    chk("post_rst_dest", 102, 32'(destination), 32'd0);
    chk("post_rst_pending", 102, 32'(pending), 32'd0);
    chk("post_rst_fc", 102, 32'(frame_count), 32'd1);
    step();

`ifdef SNAPSHOT_OVERWRITE_EN
    // Two updates in one frame: the later one wins at the tick.
    drive(10'd5, 10'd100, 1'b1, 8'h11, 2'd1, 26'd1);
    step();
    drive(10'd5, 10'd101, 1'b1, 8'h22, 2'd2, 26'd2);
    @(negedge pixel_clk);
    chk("ovr_ready", 200, 32'(upd_ready), 32'd1);
    step();
    drive(10'd0, 10'd480, 1'b0, 8'h00, 2'd0, 26'd0);
    step();
    drive(10'd5, 10'd100, 1'b0, 8'h00, 2'd0, 26'd0);
    @(negedge pixel_clk);
    chk("ovr_dest", 201, 32'(destination), 32'h22);
    chk("ovr_ppl", 201, 32'(people_data), 32'd2);
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
